seg7_scan_decoder: RTL



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_to_digit.sv | 30 +++
 rtl/seg7_scan_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment tables used by both the display encoder and the scan decoder.
package seg7_pkg;

    // Segment patterns, bit 6 = g down to bit 0 = a, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_class_e;

endpackage

// File: rtl/seg7_pattern_to_digit.sv
// Combinational 7-segment pattern to BCD/blank/invalid code decoder.
module seg7_pattern_to_digit
    import seg7_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] code,
    output logic       is_invalid
);

    // Table lookup; anything not in the table is reported as invalid.
    always_comb begin
        code = CODE_INVALID;
        case (segments)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
        is_invalid = (code == CODE_INVALID);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and latches each digit's value once it
// has been stable for STABLE consecutive samples.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 2,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          segments,
    input  logic [NDIG-1:0]     digit_sel,
    input  logic                clear_err,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic                update,
    output logic                pat_err,
    output logic                sel_err
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    function automatic sel_class_e classify(input logic [NDIG-1:0] sel);
        sel_class_e cls;
        if (sel == {NDIG{1'b0}}) begin
            cls = SEL_IDLE;
        end else if ((sel & (sel - {{(NDIG-1){1'b0}}, 1'b1})) == {NDIG{1'b0}}) begin
            cls = SEL_ONE;
        end else begin
            cls = SEL_MULTI;
        end
        return cls;
    endfunction

    logic [NDIG-1:0]   prev_sel_r;
    logic [6:0]        prev_seg_r;
    logic              hist_vld_r;
    logic [3:0]        cnt_r;
    logic [4*NDIG-1:0] digits_r;
    logic [NDIG-1:0]   valid_r;
    logic              update_r;
    logic              pat_err_r;
    logic              sel_err_r;

    sel_class_e        sel_class_s;
    logic              same_s;
    logic [3:0]        cnt_nxt_s;
    logic              latch_s;
    logic [3:0]        code_s;
    logic              is_invalid_s;
    logic [4*NDIG-1:0] digits_nxt_s;
    logic [NDIG-1:0]   valid_nxt_s;
    logic              pat_err_nxt_s;
    logic              sel_err_nxt_s;

    seg7_pattern_to_digit u_decode (
        .segments   (segments),
        .code       (code_s),
        .is_invalid (is_invalid_s)
    );

    // Stability counter and latch decision; the latch fires only on the
    // STABLE-1 -> STABLE step so a held pattern latches exactly once.
    always_comb begin
        sel_class_s = classify(digit_sel);
        same_s      = hist_vld_r && (digit_sel == prev_sel_r) && (segments == prev_seg_r);
        cnt_nxt_s   = 4'd0;
        case (sel_class_s)
            SEL_ONE: begin
                if (same_s) begin
                    cnt_nxt_s = (cnt_r == STABLE_C) ? STABLE_C : cnt_r + 4'd1;
                end else begin
                    cnt_nxt_s = 4'd1;
                end
            end
            SEL_IDLE:  cnt_nxt_s = 4'd0;
            SEL_MULTI: cnt_nxt_s = 4'd0;
            default:   cnt_nxt_s = 4'd0;
        endcase
        latch_s = (cnt_r == (STABLE_C - 4'd1)) && (cnt_nxt_s == STABLE_C);
    end

    // Per-position latch targets and sticky flags (a new error beats clear_err).
    always_comb begin
        digits_nxt_s = digits_r;
        valid_nxt_s  = valid_r;
        for (int i = 0; i < NDIG; i++) begin
            digits_nxt_s[4*i +: 4] = (latch_s && digit_sel[i]) ? code_s : digits_r[4*i +: 4];
            valid_nxt_s[i]         = (latch_s && digit_sel[i]) ? 1'b1   : valid_r[i];
        end
        pat_err_nxt_s = (latch_s && is_invalid_s)   ? 1'b1 : (clear_err ? 1'b0 : pat_err_r);
        sel_err_nxt_s = (sel_class_s == SEL_MULTI)  ? 1'b1 : (clear_err ? 1'b0 : sel_err_r);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel_r <= {NDIG{1'b0}};
            prev_seg_r <= 7'h00;
            hist_vld_r <= 1'b0;
            cnt_r      <= 4'd0;
            digits_r   <= {(4*NDIG){1'b0}};
            valid_r    <= {NDIG{1'b0}};
            update_r   <= 1'b0;
            pat_err_r  <= 1'b0;
            sel_err_r  <= 1'b0;
        end else begin
            prev_sel_r <= digit_sel;
            prev_seg_r <= segments;
            hist_vld_r <= (sel_class_s == SEL_ONE);
            cnt_r      <= cnt_nxt_s;
            digits_r   <= digits_nxt_s;
            valid_r    <= valid_nxt_s;
            update_r   <= latch_s;
            pat_err_r  <= pat_err_nxt_s;
            sel_err_r  <= sel_err_nxt_s;
        end
    end

    assign digits  = digits_r;
    assign valid   = valid_r;
    assign update  = update_r;
    assign pat_err = pat_err_r;
    assign sel_err = sel_err_r;

endmodule
